// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and branch-flush bubbles.
// Optional saturating load-use bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_read_data1,
  input  logic [31:0] id_read_data2,
  input  logic [31:0] id_sign_ext,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rt,
  input  logic [3:0]  id_alu_op,
  input  logic        id_alu_src,
  input  logic        id_reg_dst,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        id_reg_write,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_read_data1,
  output logic [31:0] ex_read_data2,
  output logic [31:0] ex_sign_ext,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_write_reg,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_reg_write,
  output logic        stall_if_id,
  output logic [31:0] bubble_cnt
);

  logic        valid_q, valid_d;
  logic [31:0] read_data1_q, read_data1_d;
  logic [31:0] read_data2_q, read_data2_d;
  logic [31:0] sign_ext_q, sign_ext_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        alu_src_q, alu_src_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        reg_write_q, reg_write_d;

  logic        hazard;
  logic        load;

  // A load in EX whose target feeds the ID instruction; r0 never creates a dependency.
  always_comb begin
    hazard = valid_q & mem_read_q & (rt_q != 5'd0) & id_valid &
             ((rt_q == id_rs) | (id_uses_rt & (rt_q == id_rt)));
    stall_if_id = hazard & ~flush;
    load = ~flush & ~hazard;
  end

  always_comb begin
    valid_d      = 1'b0;
    read_data1_d = read_data1_q;
    read_data2_d = read_data2_q;
    sign_ext_d   = sign_ext_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    write_reg_d  = write_reg_q;
    alu_op_d     = 4'd0;
    alu_src_d    = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_write_d  = 1'b0;
    if (load) begin
      valid_d      = id_valid;
      read_data1_d = id_read_data1;
      read_data2_d = id_read_data2;
      sign_ext_d   = id_sign_ext;
      rs_d         = id_rs;
      rt_d         = id_rt;
      write_reg_d  = id_reg_dst ? id_rd : id_rt;
      // Controls of a non-valid slot are zeroed so a bubble can never write state.
      if (id_valid) begin
        alu_op_d     = id_alu_op;
        alu_src_d    = id_alu_src;
        mem_read_d   = id_mem_read;
        mem_write_d  = id_mem_write;
        mem_to_reg_d = id_mem_to_reg;
        reg_write_d  = id_reg_write;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      read_data1_q <= 32'd0;
      read_data2_q <= 32'd0;
      sign_ext_q   <= 32'd0;
      rs_q         <= 5'd0;
      rt_q         <= 5'd0;
      write_reg_q  <= 5'd0;
      alu_op_q     <= 4'd0;
      alu_src_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      read_data1_q <= read_data1_d;
      read_data2_q <= read_data2_d;
      sign_ext_q   <= sign_ext_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      write_reg_q  <= write_reg_d;
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Only hazard bubbles count; flush wins over hazard and is excluded via stall_if_id.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (stall_if_id && (bubble_cnt_q != 32'hFFFF_FFFF))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bubble_cnt_q <= 32'd0;
    else     bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = 32'd0;
`endif

  assign ex_valid      = valid_q;
  assign ex_read_data1 = read_data1_q;
  assign ex_read_data2 = read_data2_q;
  assign ex_sign_ext   = sign_ext_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_write_reg  = write_reg_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_alu_src    = alu_src_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_reg_write  = reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared every cycle against a behavioural pipeline-register model.
module tb_id_ex_stage;

  logic        clk, rst;
  logic        id_valid, id_uses_rt, flush;
  logic [31:0] id_read_data1, id_read_data2, id_sign_ext;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_reg_dst, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write;
  logic        ex_valid;
  logic [31:0] ex_read_data1, ex_read_data2, ex_sign_ext;
  logic [4:0]  ex_rs, ex_rt, ex_write_reg;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic        stall_if_id;
  logic [31:0] bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_sign_ext(id_sign_ext),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_reg_write(id_reg_write), .flush(flush),
    .ex_valid(ex_valid), .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
    .ex_sign_ext(ex_sign_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .stall_if_id(stall_if_id), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        valid;
    bit [31:0] rd1, rd2, se;
    bit [4:0]  rs, rt, wr;
    bit [3:0]  alu_op;
    bit        alu_src, mr, mw, m2r, rw;
  } ex_t;

  ex_t         m;
  bit [31:0]   m_cnt;
  bit          m_cnt_preload;
  bit [31:0]   m_cnt_preload_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Load-use dependency of the current ID inputs on the modelled EX contents.
  function automatic bit model_hazard();
    return m.valid && m.mr && (m.rt != 0) && (id_valid === 1'b1) &&
           ((m.rt == id_rs) || ((id_uses_rt === 1'b1) && (m.rt == id_rt)));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m = '{default: 0};
      m_cnt = 0;
    end else begin
      bit h;
      h = model_hazard();
      if (flush || h) begin
        m.valid = 0; m.alu_op = 0; m.alu_src = 0; m.mr = 0; m.mw = 0; m.m2r = 0; m.rw = 0;
`ifdef ID_EX_BUBBLE_CNT_EN
        if (!flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
      end else begin
        m.valid = id_valid;
        m.rd1 = id_read_data1; m.rd2 = id_read_data2; m.se = id_sign_ext;
        m.rs = id_rs; m.rt = id_rt;
        m.wr = id_reg_dst ? id_rd : id_rt;
        m.alu_op  = id_valid ? id_alu_op : 4'd0;
        m.alu_src = id_valid && id_alu_src;
        m.mr      = id_valid && id_mem_read;
        m.mw      = id_valid && id_mem_write;
        m.m2r     = id_valid && id_mem_to_reg;
        m.rw      = id_valid && id_reg_write;
      end
    end
  end

  always @(posedge m_cnt_preload) m_cnt = m_cnt_preload_val;

  // Every cycle: outputs were loaded at the rising edge, inputs were driven 1ns later.
  always @(negedge clk) begin
    chk("ex_valid", ex_valid, m.valid);
    chk("ex_read_data1", ex_read_data1, m.rd1);
    chk("ex_read_data2", ex_read_data2, m.rd2);
    chk("ex_sign_ext", ex_sign_ext, m.se);
    chk("ex_rs", ex_rs, m.rs);
    chk("ex_rt", ex_rt, m.rt);
    chk("ex_write_reg", ex_write_reg, m.wr);
    chk("ex_alu_op", ex_alu_op, m.alu_op);
    chk("ex_alu_src", ex_alu_src, m.alu_src);
    chk("ex_mem_read", ex_mem_read, m.mr);
    chk("ex_mem_write", ex_mem_write, m.mw);
    chk("ex_mem_to_reg", ex_mem_to_reg, m.m2r);
    chk("ex_reg_write", ex_reg_write, m.rw);
    chk("stall_if_id", stall_if_id, model_hazard() && !flush);
    chk("bubble_cnt", bubble_cnt, m_cnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_uses_rt = 0; flush = 0;
    id_read_data1 = 0; id_read_data2 = 0; id_sign_ext = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_alu_op = 0;
    id_alu_src = 0; id_reg_dst = 0; id_mem_read = 0; id_mem_write = 0;
    id_mem_to_reg = 0; id_reg_write = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    set_idle();
    step();
    chk("reset ex_valid", ex_valid, 0);
    chk("reset ex_reg_write", ex_reg_write, 0);
    chk("reset ex_read_data1", ex_read_data1, 0);
    chk("reset bubble_cnt", bubble_cnt, 0);
    chk("reset stall", stall_if_id, 0);
    rst = 0;
  endtask

  task automatic present_load(input logic [4:0] rt);
    set_idle();
    id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1;
    id_rt = rt; id_rs = 5'd3; id_alu_op = 4'd2; id_alu_src = 1;
  endtask

  task automatic present_user(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt);
    set_idle();
    id_valid = 1; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt;
    id_rd = 5'd12; id_reg_dst = 1; id_reg_write = 1; id_alu_op = 4'd1;
    id_read_data1 = 32'hA5A5_0001;
  endtask

  function automatic logic [4:0] rnd_reg();
    logic [4:0] pick [5];
    pick[0] = 5'd0; pick[1] = 5'd1; pick[2] = 5'd8; pick[3] = 5'd9;
    pick[4] = 5'($urandom_range(31));
    return pick[$urandom_range(4)];
  endfunction

  initial begin
    logic [31:0] exp_cnt;
    rst = 0;
    set_idle();
    #1 rst = 1;
    #20;
    do_reset();

    // Pass-through of operands and controls.
    set_idle();
    id_valid = 1; id_read_data2 = 32'h0000_1234; id_sign_ext = 32'hFFFF_FFF0;
    id_alu_src = 1; id_reg_dst = 1; id_rd = 5'd5; id_rs = 5'd1; id_rt = 5'd2;
    step();
    chk("pass ex_valid", ex_valid, 1);
    chk("pass ex_read_data2", ex_read_data2, 32'h0000_1234);
    chk("pass ex_sign_ext", ex_sign_ext, 32'hFFFF_FFF0);
    chk("pass ex_alu_src", ex_alu_src, 1);
    chk("pass ex_write_reg", ex_write_reg, 5);

    // Load-use stall on rs.
    do_reset();
    present_load(5'd8);
    step();
    present_user(5'd8, 5'd4, 1'b1);
    #1 chk("lu stall", stall_if_id, 1);
    step();
    chk("lu bubble ex_valid", ex_valid, 0);
    chk("lu bubble ex_reg_write", ex_reg_write, 0);
    chk("lu stall cleared", stall_if_id, 0);
    step();
    chk("lu loaded ex_valid", ex_valid, 1);
    chk("lu loaded ex_rs", ex_rs, 8);
    chk("lu loaded ex_write_reg", ex_write_reg, 12);
`ifdef ID_EX_BUBBLE_CNT_EN
    exp_cnt = 32'd1;
`else
    exp_cnt = 32'd0;
`endif
    chk("lu bubble_cnt", bubble_cnt, exp_cnt);

    // r0 never stalls; rt only counts when used.
    do_reset();
    present_load(5'd0);
    step();
    present_user(5'd0, 5'd0, 1'b1);
    #1 chk("r0 no stall", stall_if_id, 0);
    present_load(5'd9);
    step();
    present_user(5'd1, 5'd9, 1'b0);
    #1 chk("rt unused no stall", stall_if_id, 0);
    id_uses_rt = 1;
    #1 chk("rt used stall", stall_if_id, 1);

    // Flush beats hazard and is not counted.
    do_reset();
    present_load(5'd8);
    step();
    present_user(5'd8, 5'd0, 1'b0);
    flush = 1;
    #1 chk("flush hides stall", stall_if_id, 0);
    step();
    chk("flush bubble ex_valid", ex_valid, 0);
    chk("flush bubble ex_reg_write", ex_reg_write, 0);
    chk("flush bubble_cnt", bubble_cnt, 0);

    // Asynchronous reset while a stall is pending.
    do_reset();
    present_load(5'd8);
    step();
    present_user(5'd8, 5'd0, 1'b0);
    #1 chk("pre-rst stall", stall_if_id, 1);
    chk("pre-rst ex_reg_write", ex_reg_write, 1);
    rst = 1;
    #1;
    chk("async rst ex_reg_write", ex_reg_write, 0);
    chk("async rst ex_valid", ex_valid, 0);
    chk("async rst stall", stall_if_id, 0);
    rst = 0;
    step();
    chk("post-rst load ex_valid", ex_valid, 1);
    chk("post-rst load ex_rs", ex_rs, 8);

`ifdef ID_EX_BUBBLE_CNT_EN
    // Saturation from a preloaded count.
    do_reset();
    force dut.bubble_cnt_q = 32'hFFFF_FFFE;
    m_cnt_preload_val = 32'hFFFF_FFFE;
    m_cnt_preload = 1;
    #1 release dut.bubble_cnt_q;
    m_cnt_preload = 0;
    for (int k = 0; k < 2; k++) begin
      present_load(5'd8);
      step();
      present_user(5'd8, 5'd0, 1'b0);
      step();
      step();
    end
    chk("saturated bubble_cnt", bubble_cnt, 32'hFFFF_FFFF);
`endif

    // Randomized traffic; the upstream holds ID while a stall is expected.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!(model_hazard() && !flush)) begin
        id_valid      = ($urandom_range(7) != 0);
        id_read_data1 = $urandom;
        id_read_data2 = $urandom;
        id_sign_ext   = $urandom;
        id_rs         = rnd_reg();
        id_rt         = rnd_reg();
        id_rd         = rnd_reg();
        id_uses_rt    = 1'($urandom_range(1));
        id_alu_op     = 4'($urandom_range(15));
        id_alu_src    = 1'($urandom_range(1));
        id_reg_dst    = 1'($urandom_range(1));
        id_mem_read   = ($urandom_range(2) == 0);
        id_mem_write  = 1'($urandom_range(1));
        id_mem_to_reg = 1'($urandom_range(1));
        id_reg_write  = 1'($urandom_range(1));
      end
      flush = ($urandom_range(7) == 0);
      if ($urandom_range(299) == 0) begin
        #1 rst = 1;
        #1 rst = 0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; the ports are named clk and rst.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port id_valid, input, 1 bit: the ID-stage instruction is real, not a bubble.
REQ-005 SHALL have ports id_read_data1, id_read_data2 and id_sign_ext, input, 32 bits each: the ID operands.
REQ-006 SHALL have ports id_rs, id_rt and id_rd, input, 5 bits each: the register specifiers.
REQ-007 SHALL have port id_uses_rt, input, 1 bit: the ID instruction reads rt as a source.
REQ-008 SHALL have control input ports: id_alu_op (4 bits), plus 1 bit each for id_alu_src, id_reg_dst, id_mem_read, id_mem_write, id_mem_to_reg and id_reg_write.
REQ-009 SHALL have port flush, input, 1 bit: a branch is taken, so kill the ID instruction.
REQ-010 SHALL have registered output ports ex_valid, ex_read_data1, ex_read_data2, ex_sign_ext, ex_rs, ex_rt, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg and ex_reg_write; each has the same width as its id_ input.
REQ-011 SHALL have port ex_write_reg, output, 5 bits: the registered destination register.
REQ-012 SHALL have port stall_if_id, output, 1 bit, combinational: hold PC and the IF/ID register this cycle.
REQ-013 SHALL have port bubble_cnt, output, 32 bits: load-use bubble count (see Configuration).

Function
REQ-014 SHALL define hazard = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
REQ-015 SHALL drive stall_if_id = hazard & ~flush, combinationally in the same cycle, with no register.
REQ-016 SHALL, on a rising clk edge with flush=1, load a bubble: ex_valid=0 and all control outputs 0 (alu_op, alu_src, mem_read, mem_write, mem_to_reg, reg_write); data and specifier outputs hold their values. Flush takes priority over hazard.
REQ-017 SHALL, on a rising clk edge with flush=0 and hazard=1, load a bubble exactly as in REQ-016; the ID inputs are re-presented next cycle by the upstream hold.
REQ-018 SHALL, on a rising clk edge with flush=0 and hazard=0, load every id_ field into its ex_ output, with ex_valid=id_valid.
REQ-019 SHALL compute ex_write_reg at load time as id_reg_dst ? id_rd : id_rt.
REQ-020 SHALL load any id_valid=0 instruction with all control outputs forced to 0, regardless of the id_ control inputs.
REQ-021 SHALL make stall last exactly one cycle per load-use pair: the bubble clears ex_mem_read, so hazard deasserts on the next cycle.
REQ-022 SHALL have a latency of one clock from the id_ inputs to the ex_ outputs; the block has no other internal state besides the counter.

Reset
REQ-023 SHALL, while rst=1 and independent of clk, force every ex_ output to 0, ex_valid to 0 and bubble_cnt to 0.
REQ-024 SHALL drive stall_if_id to 0 during reset, because ex_valid=0.
REQ-025 SHALL, if rst asserts mid-stall, discard the pending bubble; the first edge after reset release loads from the ID inputs normally.

Configuration
REQ-026 SHALL, with macro ID_EX_BUBBLE_CNT_EN defined, increment bubble_cnt by 1 on each clk edge at which REQ-017 applies; the count saturates at 32'hFFFFFFFF, and flush-induced bubbles are not counted.
REQ-027 SHALL, without ID_EX_BUBBLE_CNT_EN, still provide the bubble_cnt port, tie it to constant 0 and build no counter logic.

Verification
REQ-028 SHALL cover pass-through: id_valid=1, id_read_data2=32'h0000_1234, id_sign_ext=32'hFFFF_FFF0, id_alu_src=1, id_reg_dst=1, id_rd=5, no hazard -> after one edge, ex_read_data2=32'h1234, ex_sign_ext=32'hFFFFFFF0, ex_alu_src=1, ex_write_reg=5.
REQ-029 SHALL cover load-use: load with rt=8 in EX, ID instruction with rs=8 -> stall_if_id=1 that cycle; next edge gives ex_valid=0 and ex_reg_write=0; the following cycle gives stall_if_id=0 and the ID instruction is loaded; bubble_cnt=1 when the macro is on.
REQ-030 SHALL cover the r0 exception and rt-unused case: load with rt=0 in EX and ID rs=0 -> stall_if_id=0; load rt=9 with ID rt=9 and id_uses_rt=0 -> stall_if_id=0.
REQ-031 SHALL cover simultaneous flush and hazard: hazard true with flush=1 -> stall_if_id=0; next edge gives a bubble and bubble_cnt unchanged.
REQ-032 SHALL cover asynchronous reset: rst pulsed between clock edges while ex_reg_write=1 and a stall is pending -> ex_reg_write=0, ex_valid=0 and stall_if_id=0 immediately, before the next clk edge.
REQ-033 SHALL cover saturation: bubble_cnt preloaded or forced to 32'hFFFFFFFE, then two load-use bubbles -> bubble_cnt=32'hFFFFFFFF with no wrap to 0.
